bullet_hit_resolver: RTL and testbench

- Sits directly downstream of both per-player bullet blocks and feeds back their kill inputs: barrier_collision, player_hit, armor_hit and bullet_on_bullet_hit.
- Once per frame, tests each active bullet against the other bullet, the opposing tank and the fixed barriers.
- Produces registered one-frame hit pulses and owns per-player armor, lives and invulnerability state, plus game_over and winner.

---
 rtl/bullet_hit_resolver_pkg.sv | 34 +++
 rtl/bullet_hit_resolver_if.sv | 38 +++
 rtl/bullet_hit_resolver_box_overlap.sv | 26 ++
 rtl/bullet_hit_resolver.sv | 166 ++++++++++++++++
 tb/tb_bullet_hit_resolver.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/bullet_hit_resolver_pkg.sv
// rtl/bullet_hit_resolver_pkg.sv - shared types, barrier map and helpers for the hit resolver
package bullet_hit_pkg;

  localparam int COORD_W      = 10;
  localparam int NUM_BARRIERS = 4;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] hw;
    logic [COORD_W-1:0] hh;
  } barrier_rect_t;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    P1   = 2'b01,
    P2   = 2'b10,
    DRAW = 2'b11
  } winner_t;

  // Fixed playfield walls: centre plus half-extents.
  localparam barrier_rect_t BARRIERS [NUM_BARRIERS] = '{
    '{x: 10'd320, y: 10'd240, hw: 10'd40, hh: 10'd10},
    '{x: 10'd160, y: 10'd120, hw: 10'd10, hh: 10'd40},
    '{x: 10'd480, y: 10'd360, hw: 10'd10, hh: 10'd40},
    '{x: 10'd320, y: 10'd60,  hw: 10'd60, hh: 10'd8}
  };

  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/bullet_hit_resolver_if.sv
// rtl/bullet_hit_resolver_if.sv - bullet/tank geometry in, kill pulses and player state out
interface bullet_hit_resolver_if;
  import bullet_hit_pkg::*;

  logic [COORD_W-1:0] b1_x, b1_y, b1_s;
  logic [COORD_W-1:0] b2_x, b2_y, b2_s;
  logic               b1_on, b2_on;
  logic [COORD_W-1:0] p1_x, p1_y, p1_s;
  logic [COORD_W-1:0] p2_x, p2_y, p2_s;
  logic               p1_armor_pickup, p2_armor_pickup;

  logic b1_barrier_collision, b1_player_hit, b1_armor_hit, b1_bullet_hit;
  logic b2_barrier_collision, b2_player_hit, b2_armor_hit, b2_bullet_hit;
  logic [2:0] p1_lives, p2_lives;
  logic [1:0] p1_armor, p2_armor;
  logic       p1_invuln, p2_invuln;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output b1_x, b1_y, b1_s, b2_x, b2_y, b2_s, b1_on, b2_on,
    output p1_x, p1_y, p1_s, p2_x, p2_y, p2_s, p1_armor_pickup, p2_armor_pickup,
    input  b1_barrier_collision, b1_player_hit, b1_armor_hit, b1_bullet_hit,
    input  b2_barrier_collision, b2_player_hit, b2_armor_hit, b2_bullet_hit,
    input  p1_lives, p2_lives, p1_armor, p2_armor, p1_invuln, p2_invuln,
    input  game_over, winner
  );

  modport slave (
    input  b1_x, b1_y, b1_s, b2_x, b2_y, b2_s, b1_on, b2_on,
    input  p1_x, p1_y, p1_s, p2_x, p2_y, p2_s, p1_armor_pickup, p2_armor_pickup,
    output b1_barrier_collision, b1_player_hit, b1_armor_hit, b1_bullet_hit,
    output b2_barrier_collision, b2_player_hit, b2_armor_hit, b2_bullet_hit,
    output p1_lives, p2_lives, p1_armor, p2_armor, p1_invuln, p2_invuln,
    output game_over, winner
  );

endinterface

// File: rtl/bullet_hit_resolver_box_overlap.sv
// rtl/bullet_hit_resolver_box_overlap.sv - combinational AABB overlap of two centred boxes
module box_overlap
  import bullet_hit_pkg::*;
(
  input  logic [COORD_W-1:0] a_x,
  input  logic [COORD_W-1:0] a_y,
  input  logic [COORD_W-1:0] a_hw,
  input  logic [COORD_W-1:0] a_hh,
  input  logic [COORD_W-1:0] b_x,
  input  logic [COORD_W-1:0] b_y,
  input  logic [COORD_W-1:0] b_hw,
  input  logic [COORD_W-1:0] b_hh,
  output logic               overlap
);

  logic [COORD_W:0] dx, dy, sx, sy;

  // One extra bit so the summed extents never wrap.
  assign dx = {1'b0, abs_diff(a_x, b_x)};
  assign dy = {1'b0, abs_diff(a_y, b_y)};
  assign sx = {1'b0, a_hw} + {1'b0, b_hw};
  assign sy = {1'b0, a_hh} + {1'b0, b_hh};

  assign overlap = (dx <= sx) && (dy <= sy);

endmodule

// File: rtl/bullet_hit_resolver.sv
// rtl/bullet_hit_resolver.sv - per-frame bullet collision resolve with armor, lives and invuln state
module bullet_hit_resolver
  import bullet_hit_pkg::*;
#(
  parameter int LIVES_INIT    = 3,
  parameter int ARMOR_MAX     = 2,
  parameter int INVULN_FRAMES = 60
) (
  input  logic                 frame_clk,
  input  logic                 Reset_n,
  bullet_hit_resolver_if.slave bus
);

  localparam logic [2:0] LIVES_RST = 3'(LIVES_INIT);
  localparam logic [1:0] ARMOR_RST = 2'(ARMOR_MAX);
  localparam logic [7:0] INV_LOAD  = 8'(INVULN_FRAMES);

  logic ov_bb, ov_b1p2, ov_b2p1;
  logic [NUM_BARRIERS-1:0] b1_bar_ov, b2_bar_ov;

  box_overlap u_bb (
    .a_x(bus.b1_x), .a_y(bus.b1_y), .a_hw(bus.b1_s), .a_hh(bus.b1_s),
    .b_x(bus.b2_x), .b_y(bus.b2_y), .b_hw(bus.b2_s), .b_hh(bus.b2_s),
    .overlap(ov_bb)
  );

  box_overlap u_b1p2 (
    .a_x(bus.b1_x), .a_y(bus.b1_y), .a_hw(bus.b1_s), .a_hh(bus.b1_s),
    .b_x(bus.p2_x), .b_y(bus.p2_y), .b_hw(bus.p2_s), .b_hh(bus.p2_s),
    .overlap(ov_b1p2)
  );

  box_overlap u_b2p1 (
    .a_x(bus.b2_x), .a_y(bus.b2_y), .a_hw(bus.b2_s), .a_hh(bus.b2_s),
    .b_x(bus.p1_x), .b_y(bus.p1_y), .b_hw(bus.p1_s), .b_hh(bus.p1_s),
    .overlap(ov_b2p1)
  );

  for (genvar i = 0; i < NUM_BARRIERS; i++) begin : g_bar
    box_overlap u_b1 (
      .a_x(bus.b1_x), .a_y(bus.b1_y), .a_hw(bus.b1_s), .a_hh(bus.b1_s),
      .b_x(BARRIERS[i].x), .b_y(BARRIERS[i].y), .b_hw(BARRIERS[i].hw), .b_hh(BARRIERS[i].hh),
      .overlap(b1_bar_ov[i])
    );
    box_overlap u_b2 (
      .a_x(bus.b2_x), .a_y(bus.b2_y), .a_hw(bus.b2_s), .a_hh(bus.b2_s),
      .b_x(BARRIERS[i].x), .b_y(BARRIERS[i].y), .b_hw(BARRIERS[i].hw), .b_hh(BARRIERS[i].hh),
      .overlap(b2_bar_ov[i])
    );
  end

  logic [2:0] p1_lives_q, p2_lives_q;
  logic [1:0] p1_armor_q, p2_armor_q;
  logic [7:0] p1_cnt_q, p2_cnt_q;
  logic       game_over_q;
  winner_t    winner_q;

  logic b1_barrier_q, b1_player_q, b1_armor_q, b1_bullet_q;
  logic b2_barrier_q, b2_player_q, b2_armor_q, b2_bullet_q;

  logic bb_hit, b1_tank, b2_tank, b1_bar, b2_bar;
  logic p1_lose, p2_lose;
  logic [2:0] p1_lives_nxt, p2_lives_nxt;

  // Priority per bullet: bullet-on-bullet, then tank, then barrier.
  always_comb begin
    bb_hit  = bus.b1_on && bus.b2_on && ov_bb;
    b1_tank = bus.b1_on && !bb_hit && ov_b1p2;
    b2_tank = bus.b2_on && !bb_hit && ov_b2p1;
    b1_bar  = bus.b1_on && !bb_hit && !ov_b1p2 && (|b1_bar_ov);
    b2_bar  = bus.b2_on && !bb_hit && !ov_b2p1 && (|b2_bar_ov);

    p2_lose = b1_tank && (p2_armor_q == 2'd0) && (p2_cnt_q == 8'd0);
    p1_lose = b2_tank && (p1_armor_q == 2'd0) && (p1_cnt_q == 8'd0);

    p1_lives_nxt = (p1_lose && p1_lives_q != 3'd0) ? p1_lives_q - 3'd1 : p1_lives_q;
    p2_lives_nxt = (p2_lose && p2_lives_q != 3'd0) ? p2_lives_q - 3'd1 : p2_lives_q;
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      b1_barrier_q <= 1'b0;
      b1_player_q  <= 1'b0;
      b1_armor_q   <= 1'b0;
      b1_bullet_q  <= 1'b0;
      b2_barrier_q <= 1'b0;
      b2_player_q  <= 1'b0;
      b2_armor_q   <= 1'b0;
      b2_bullet_q  <= 1'b0;
      p1_lives_q   <= LIVES_RST;
      p2_lives_q   <= LIVES_RST;
      p1_armor_q   <= ARMOR_RST;
      p2_armor_q   <= ARMOR_RST;
      p1_cnt_q     <= 8'd0;
      p2_cnt_q     <= 8'd0;
      game_over_q  <= 1'b0;
      winner_q     <= NONE;
    end else begin
      // Pulses keep flowing after game over so bullets are still retired.
      b1_bullet_q  <= bb_hit;
      b2_bullet_q  <= bb_hit;
      b1_armor_q   <= b1_tank && (p2_armor_q != 2'd0);
      b1_player_q  <= b1_tank && (p2_armor_q == 2'd0);
      b2_armor_q   <= b2_tank && (p1_armor_q != 2'd0);
      b2_player_q  <= b2_tank && (p1_armor_q == 2'd0);
      b1_barrier_q <= b1_bar;
      b2_barrier_q <= b2_bar;

      if (!game_over_q) begin
        p1_lives_q <= p1_lives_nxt;
        p2_lives_q <= p2_lives_nxt;

        if (bus.p1_armor_pickup) begin
          p1_armor_q <= ARMOR_RST;
        end else if (b2_tank && p1_armor_q != 2'd0) begin
          p1_armor_q <= p1_armor_q - 2'd1;
        end
        if (bus.p2_armor_pickup) begin
          p2_armor_q <= ARMOR_RST;
        end else if (b1_tank && p2_armor_q != 2'd0) begin
          p2_armor_q <= p2_armor_q - 2'd1;
        end

        if (p1_lose) begin
          p1_cnt_q <= INV_LOAD;
        end else if (p1_cnt_q != 8'd0) begin
          p1_cnt_q <= p1_cnt_q - 8'd1;
        end
        if (p2_lose) begin
          p2_cnt_q <= INV_LOAD;
        end else if (p2_cnt_q != 8'd0) begin
          p2_cnt_q <= p2_cnt_q - 8'd1;
        end

        if (p1_lives_nxt == 3'd0 || p2_lives_nxt == 3'd0) begin
          game_over_q <= 1'b1;
          if (p1_lives_nxt == 3'd0 && p2_lives_nxt == 3'd0) begin
            winner_q <= DRAW;
          end else if (p1_lives_nxt == 3'd0) begin
            winner_q <= P2;
          end else begin
            winner_q <= P1;
          end
        end
      end
    end
  end

  assign bus.b1_barrier_collision = b1_barrier_q;
  assign bus.b1_player_hit        = b1_player_q;
  assign bus.b1_armor_hit         = b1_armor_q;
  assign bus.b1_bullet_hit        = b1_bullet_q;
  assign bus.b2_barrier_collision = b2_barrier_q;
  assign bus.b2_player_hit        = b2_player_q;
  assign bus.b2_armor_hit         = b2_armor_q;
  assign bus.b2_bullet_hit        = b2_bullet_q;
  assign bus.p1_lives             = p1_lives_q;
  assign bus.p2_lives             = p2_lives_q;
  assign bus.p1_armor             = p1_armor_q;
  assign bus.p2_armor             = p2_armor_q;
  assign bus.p1_invuln            = (p1_cnt_q != 8'd0);
  assign bus.p2_invuln            = (p2_cnt_q != 8'd0);
  assign bus.game_over            = game_over_q;
  assign bus.winner               = winner_q;

endmodule

// File: tb/tb_bullet_hit_resolver.sv
// tb/tb_bullet_hit_resolver.sv - directed self-checking bench for bullet_hit_resolver
module tb_bullet_hit_resolver;

  logic frame_clk;
  logic Reset_n;
  int   checks;
  int   errors;

  bullet_hit_resolver_if bus ();

  bullet_hit_resolver #(
    .LIVES_INIT(3), .ARMOR_MAX(2), .INVULN_FRAMES(60)
  ) dut (
    .frame_clk(frame_clk),
    .Reset_n  (Reset_n),
    .bus      (bus)
  );

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.b1_on = 1'b0;
    bus.b2_on = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_b1(input string tag, input int bh, input int ph, input int ah, input int bc);
    check_eq({tag, "_b1_bullet"}, bus.b1_bullet_hit, bh);
    check_eq({tag, "_b1_player"}, bus.b1_player_hit, ph);
    check_eq({tag, "_b1_armor"}, bus.b1_armor_hit, ah);
    check_eq({tag, "_b1_barrier"}, bus.b1_barrier_collision, bc);
  endtask

  task automatic check_b2(input string tag, input int bh, input int ph, input int ah, input int bc);
    check_eq({tag, "_b2_bullet"}, bus.b2_bullet_hit, bh);
    check_eq({tag, "_b2_player"}, bus.b2_player_hit, ph);
    check_eq({tag, "_b2_armor"}, bus.b2_armor_hit, ah);
    check_eq({tag, "_b2_barrier"}, bus.b2_barrier_collision, bc);
  endtask

  task automatic check_reset_state(input string tag);
    check_b1(tag, 0, 0, 0, 0);
    check_b2(tag, 0, 0, 0, 0);
    check_eq({tag, "_p1_lives"}, bus.p1_lives, 3);
    check_eq({tag, "_p2_lives"}, bus.p2_lives, 3);
    check_eq({tag, "_p1_armor"}, bus.p1_armor, 2);
    check_eq({tag, "_p2_armor"}, bus.p2_armor, 2);
    check_eq({tag, "_p1_invuln"}, bus.p1_invuln, 0);
    check_eq({tag, "_p2_invuln"}, bus.p2_invuln, 0);
    check_eq({tag, "_game_over"}, bus.game_over, 0);
    check_eq({tag, "_winner"}, bus.winner, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset_n = 1'b1;
    bus.b1_x = 10'd0; bus.b1_y = 10'd0; bus.b1_s = 10'd2; bus.b1_on = 1'b0;
    bus.b2_x = 10'd0; bus.b2_y = 10'd0; bus.b2_s = 10'd2; bus.b2_on = 1'b0;
    bus.p1_x = 10'd500; bus.p1_y = 10'd50;  bus.p1_s = 10'd8;
    bus.p2_x = 10'd600; bus.p2_y = 10'd400; bus.p2_s = 10'd8;
    bus.p1_armor_pickup = 1'b0;
    bus.p2_armor_pickup = 1'b0;

    #2 Reset_n = 1'b0;
    #20;
    check_reset_state("rst");
    tick();
    Reset_n = 1'b1;

    // Armor absorbs the first two hits on P2.
    bus.b1_x = 10'd100; bus.b1_y = 10'd100; bus.b1_s = 10'd2;
    bus.p2_x = 10'd104; bus.p2_y = 10'd100;
    bus.b1_on = 1'b1;
    tick();
    check_b1("ah1", 0, 0, 1, 0);
    check_eq("ah1_p2_armor", bus.p2_armor, 1);
    check_eq("ah1_p2_lives", bus.p2_lives, 3);
    idle(1);
    check_eq("ah1_clear", bus.b1_armor_hit, 0);
    check_eq("ah1_clear_armor", bus.p2_armor, 1);
    bus.b1_on = 1'b1;
    tick();
    check_b1("ah2", 0, 0, 1, 0);
    check_eq("ah2_p2_armor", bus.p2_armor, 0);
    idle(1);

    // Unarmored hit costs a life and starts invulnerability.
    bus.b1_on = 1'b1;
    tick();
    check_b1("ph1", 0, 1, 0, 0);
    check_eq("ph1_p2_lives", bus.p2_lives, 2);
    check_eq("ph1_p2_invuln", bus.p2_invuln, 1);
    idle(9);
    bus.b1_on = 1'b1;
    tick();
    check_b1("ph2", 0, 1, 0, 0);
    check_eq("ph2_p2_lives", bus.p2_lives, 2);
    check_eq("ph2_p2_invuln", bus.p2_invuln, 1);
    idle(49);
    check_eq("inv_last_frame", bus.p2_invuln, 1);
    idle(1);
    check_eq("inv_expired", bus.p2_invuln, 0);

    // Bullet-on-bullet outranks the tank hit and leaves counters alone.
    bus.b1_x = 10'd200; bus.b1_y = 10'd200;
    bus.b2_x = 10'd203; bus.b2_y = 10'd201;
    bus.p2_x = 10'd205; bus.p2_y = 10'd200;
    bus.b1_on = 1'b1; bus.b2_on = 1'b1;
    tick();
    check_b1("bb", 1, 0, 0, 0);
    check_b2("bb", 1, 0, 0, 0);
    check_eq("bb_p2_lives", bus.p2_lives, 2);
    check_eq("bb_p2_invuln", bus.p2_invuln, 0);
    idle(1);
    check_eq("bb_clear", bus.b1_bullet_hit, 0);
    bus.p2_x = 10'd600; bus.p2_y = 10'd400;

    // Barrier hits on both bullets, and gating by b1_on.
    bus.b1_x = 10'd320; bus.b1_y = 10'd240;
    bus.b1_on = 1'b1;
    tick();
    check_b1("bar1", 0, 0, 0, 1);
    bus.b1_on = 1'b0;
    tick();
    check_b1("bar1_off", 0, 0, 0, 0);
    bus.b2_x = 10'd160; bus.b2_y = 10'd120; bus.b2_s = 10'd1;
    bus.b2_on = 1'b1;
    tick();
    check_b2("bar2", 0, 0, 0, 1);
    check_eq("bar2_b1_idle", bus.b1_barrier_collision, 0);
    idle(1);
    bus.b2_s = 10'd2;

    // Touching edges count as overlap; one pixel further does not.
    bus.b1_x = 10'd100; bus.b1_y = 10'd100;
    bus.p2_x = 10'd110; bus.p2_y = 10'd100;
    bus.b1_on = 1'b1;
    tick();
    check_b1("edge", 0, 1, 0, 0);
    check_eq("edge_p2_lives", bus.p2_lives, 1);
    idle(1);
    bus.p2_x = 10'd111;
    bus.b1_on = 1'b1;
    tick();
    check_b1("miss", 0, 0, 0, 0);
    idle(1);
    bus.p2_x = 10'd110;

    // P1 side, bullet right of the tank; pickup beats the same-frame armor hit.
    bus.b2_x = 10'd510; bus.b2_y = 10'd50;
    bus.b2_on = 1'b1;
    bus.p1_armor_pickup = 1'b1;
    tick();
    check_b2("pick", 0, 0, 1, 0);
    check_eq("pick_p1_armor", bus.p1_armor, 2);
    bus.p1_armor_pickup = 1'b0;
    tick();
    check_eq("p1_armor_a", bus.p1_armor, 1);
    tick();
    check_eq("p1_armor_b", bus.p1_armor, 0);
    tick();
    check_b2("p1_ph1", 0, 1, 0, 0);
    check_eq("p1_ph1_lives", bus.p1_lives, 2);
    check_eq("p1_ph1_invuln", bus.p1_invuln, 1);
    idle(60);
    check_eq("p1_inv_done", bus.p1_invuln, 0);
    bus.b2_on = 1'b1;
    tick();
    check_eq("p1_ph2_lives", bus.p1_lives, 1);
    check_eq("p1_ph2_go", bus.game_over, 0);
    idle(60);

    // Simultaneous final hits give a draw.
    bus.b1_on = 1'b1; bus.b2_on = 1'b1;
    tick();
    check_b1("draw", 0, 1, 0, 0);
    check_b2("draw", 0, 1, 0, 0);
    check_eq("draw_game_over", bus.game_over, 1);
    check_eq("draw_winner", bus.winner, 3);
    check_eq("draw_p1_lives", bus.p1_lives, 0);
    check_eq("draw_p2_lives", bus.p2_lives, 0);
    bus.p1_armor_pickup = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_b1("frz", 0, 1, 0, 0);
    check_eq("frz_p1_armor", bus.p1_armor, 0);
    check_eq("frz_p2_invuln", bus.p2_invuln, 1);
    check_eq("frz_p1_lives", bus.p1_lives, 0);
    check_eq("frz_winner", bus.winner, 3);
    bus.p1_armor_pickup = 1'b0;

    // Asynchronous reset mid-frame.
    #2 Reset_n = 1'b0;
    #1;
    check_reset_state("arst");
    idle(1);
    Reset_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
